nco_cfg_loader: RTL and testbench
=================================

// Module: nco_cfg_loader
// PURPOSE
//  Upstream stage of the 8-channel NCO bank. Parses a 32-bit control-word stream from the USB3 receive FIFO.
//  Maintains per-channel carrier frequency, 1.023 MHz code frequency and code phase words.
//  Presents them, registered, to the NCO bank. Each update is applied either immediately
//  or synchronously across channels on an external epoch strobe.
// PARAMETERS
//  NUM_CH     8       number of NCO channels (channel field is 3 bits)
//  DW         28      control-word width, matches NCO accumulator
//  SYNC       8'hA5   header sync byte
//  TIMEOUT    1023    max idle cycles between words of one packet
// PORTS
//  clk            in   1          system clock, single clock domain
//  rst            in   1          asynchronous, active-high reset
//  in_data        in   32         stream word from USB3 FIFO
//  in_valid       in   1          in_data valid
//  in_ready       out  1          word accepted when in_valid & in_ready
//  apply_strobe   in   1          epoch pulse; commits all deferred channels
//  fre_carrier    out  NUM_CH*DW  ch k at [k*DW +: DW]
//  fre_1023k      out  NUM_CH*DW  ch k at [k*DW +: DW]
//  pha_1023k      out  NUM_CH*DW  ch k at [k*DW +: DW]
//  upd            out  NUM_CH     1-cycle pulse, channel's active words changed
//  pending        out  NUM_CH     channel holds a deferred update
//  err_cnt        out  8          saturating count of dropped/aborted packets
// BEHAVIOUR
//  Packet = header + 3 payload words, in order:
//  - header: [31:24]=SYNC, [18:16]=ch, [15]=defer; other bits ignored.
//  - then carrier freq, code freq, code phase; each uses [DW-1:0], [31:DW] ignored.
//  FSM: IDLE -> W_CAR -> W_COD -> W_PHA -> COMMIT -> IDLE.
//  - IDLE: accepted word with [31:24]!=SYNC is dropped; err_cnt+1; stay IDLE.
//  - W_*: each accepted word is stored into the shadow field; advance.
//  - COMMIT: lasts 1 cycle; in_ready=0. in_ready=1 in every other state.
//  - defer=0: active regs of ch <= shadow at the end of COMMIT; upd[ch] pulses in that same cycle+1.
//    Latency: phase word accepted at edge N; outputs and upd change at edge N+2.
//  - defer=1: shadow[ch] written, pending[ch]<=1; active regs unchanged.
//  apply_strobe (any state):
//  - every ch with pending=1 copies shadow->active; its upd pulses; pending clears; outputs change at next edge.
//  - Strobe in the same cycle as a deferred COMMIT to ch k: strobe uses the old shadow of k.
//    The new value stays pending for the next strobe.
//  - Strobe in the same cycle as an immediate COMMIT to ch k: the immediate value wins; pending[k] clears.
//  Timeout: in W_* a 10-bit idle counter runs while no word is accepted.
//  - At TIMEOUT: abort to IDLE; shadow partial writes discarded (the packet must not reach pending/active); err_cnt+1.
//  - Counter reloads on every accepted word.
//  err_cnt saturates at 8'hFF, never wraps.
//  Rewrite of an already-pending ch with defer=1: newest shadow replaces the old; one pending bit.
//  Reset (async, any state): FSM=IDLE, in_ready=1.
//  - All fre/pha/shadow=0; upd=0, pending=0, err_cnt=0, timeout counter=0.
//  All outputs driven from flops; no combinational in->out path except in_ready from state.
// STRUCTURE
//  Package nco_cfg_pkg:
//  - SYNC value and header bit positions (CH_LSB=16, DEFER_BIT=15).
//  - FSM state encoding, TIMEOUT width.
//  Sub-module nco_cfg_chreg, instanced NUM_CH times:
//  - Holds shadow + active + pending for one channel.
//  - Inputs: wr_shadow, wr_direct, apply; outputs: 3 words, pending, upd.
//  Top level: FSM, packet staging registers, timeout counter, err_cnt.
// TESTING
//  1 Header 0xA5000000 (ch0, immediate), then 0x0123_4567, 0x0000_1000, 0x0000_0200, back-to-back.
//    -> edge N+2: fre_carrier[27:0]=0x1234567, fre_1023k=0x1000, pha=0x200.
//    -> upd=8'h01 for 1 cycle; in_ready low only in COMMIT.
//  2 Deferred packets to ch3 and ch5 (header 0xA5038000 / 0xA5058000).
//    -> pending=8'h28, outputs unchanged. apply_strobe -> both update same edge, upd=8'h28, pending=0.
//  3 Bad header 0x5A000000 -> dropped, err_cnt=1, FSM stays IDLE.
//    A following valid packet is still parsed correctly.
//  4 Header + 1 payload word, then 1023 idle cycles -> abort, err_cnt+1, no upd.
//    A next complete packet to the same ch applies correctly.
//  5 Deferred commit to ch2 coincides with apply_strobe.
//    -> old ch2 shadow applied, pending[2]=1 after; second strobe applies new value.
//  6 Assert rst mid-W_COD -> all outputs 0 asynchronously, in_ready=1.
//    Stream resumes cleanly from a new header.

Source files
------------

// File: rtl/nco_cfg_pkg.sv
// Shared constants for the NCO control-word loader.
// Holds the header sync byte and field positions, the parser state encoding,
// the packet timeout and a saturating error-count helper.
package nco_cfg_pkg;

  localparam logic [7:0] SYNC      = 8'hA5;
  localparam int         CH_LSB    = 16;
  localparam int         CH_W      = 3;
  localparam int         DEFER_BIT = 15;

  localparam int             TO_W    = 10;
  localparam logic [TO_W-1:0] TIMEOUT = 10'd1023;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAR,
    S_COD,
    S_PHA,
    S_COMMIT
  } state_t;

  // Error counter never wraps.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

endpackage

// File: rtl/nco_cfg_loader_if.sv
// Valid/ready stream carrying 32-bit control words from the USB3 receive FIFO.
//   in_data  : stream word
//   in_valid : in_data valid (master)
//   in_ready : word accepted when in_valid & in_ready (slave)
interface nco_cfg_loader_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;

  modport master (output in_data, in_valid, input in_ready);
  modport slave  (input in_data, in_valid, output in_ready);
endinterface

// File: rtl/nco_cfg_chreg.sv
// One NCO channel's register set: shadow words, active (output) words and the
// deferred-update pending flag.
//   wr_shadow : load shadow from *_in; pending <= defer
//   wr_direct : copy shadow -> active (immediate update, one cycle after wr_shadow)
//   apply     : epoch strobe; copies shadow -> active if pending
//   car/cod/pha, pending, upd : registered outputs
module nco_cfg_chreg #(
  parameter int DW = 28
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_shadow,
  input  logic          defer,
  input  logic          wr_direct,
  input  logic          apply,
  input  logic [DW-1:0] car_in,
  input  logic [DW-1:0] cod_in,
  input  logic [DW-1:0] pha_in,
  output logic [DW-1:0] car,
  output logic [DW-1:0] cod,
  output logic [DW-1:0] pha,
  output logic          pending,
  output logic          upd
);

  logic [DW-1:0] sh_car, sh_cod, sh_pha;

  // Statement order sets priority: apply reads the old shadow, and a shadow
  // write in the same cycle re-arms pending so a coincident deferred commit
  // waits for the next strobe. An immediate write clears pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_car  <= '0;
      sh_cod  <= '0;
      sh_pha  <= '0;
      car     <= '0;
      cod     <= '0;
      pha     <= '0;
      pending <= 1'b0;
      upd     <= 1'b0;
    end else begin
      upd <= 1'b0;
      if (apply && pending) begin
        car     <= sh_car;
        cod     <= sh_cod;
        pha     <= sh_pha;
        pending <= 1'b0;
        upd     <= 1'b1;
      end
      if (wr_direct) begin
        car <= sh_car;
        cod <= sh_cod;
        pha <= sh_pha;
        upd <= 1'b1;
      end
      if (wr_shadow) begin
        sh_car  <= car_in;
        sh_cod  <= cod_in;
        sh_pha  <= pha_in;
        pending <= defer;
      end
    end
  end

endmodule

// File: rtl/nco_cfg_loader.sv
// Parses header + 3 payload words from the control stream and loads the
// per-channel carrier frequency, code frequency and code phase of the NCO bank,
// either immediately or deferred to the next apply_strobe.
//   clk, rst     : clock, async active-high reset
//   s            : control-word stream (slave side)
//   apply_strobe : epoch pulse committing all pending channels
//   fre_carrier, fre_1023k, pha_1023k : ch k at [k*DW +: DW]
//   upd          : per-channel 1-cycle pulse when active words change
//   pending      : per-channel deferred update held
//   err_cnt      : saturating count of dropped/aborted packets
module nco_cfg_loader
  import nco_cfg_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DW     = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  nco_cfg_loader_if.slave      s,
  input  logic                 apply_strobe,
  output logic [NUM_CH*DW-1:0] fre_carrier,
  output logic [NUM_CH*DW-1:0] fre_1023k,
  output logic [NUM_CH*DW-1:0] pha_1023k,
  output logic [NUM_CH-1:0]    upd,
  output logic [NUM_CH-1:0]    pending,
  output logic [7:0]           err_cnt
);

  state_t          state;
  logic            in_ready_q;
  logic [CH_W-1:0] st_ch;
  logic            st_defer;
  logic [DW-1:0]   st_car, st_cod, st_pha;
  logic [TO_W-1:0] to_cnt;
  logic [NUM_CH-1:0] ch_sel, wr_shadow, direct_q;
  logic            accept;

  assign s.in_ready = in_ready_q;
  assign accept     = s.in_valid & in_ready_q;

  always_comb begin
    ch_sel        = '0;
    ch_sel[st_ch] = 1'b1;
  end

  // Staging regs shield the shadow from partial packets; the shadow is only
  // written during COMMIT.
  assign wr_shadow = (state == S_COMMIT) ? ch_sel : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready_q <= 1'b1;
      st_ch      <= '0;
      st_defer   <= 1'b0;
      st_car     <= '0;
      st_cod     <= '0;
      st_pha     <= '0;
      to_cnt     <= '0;
      err_cnt    <= '0;
      direct_q   <= '0;
    end else begin
      // Immediate updates copy shadow->active the cycle after COMMIT.
      direct_q <= (state == S_COMMIT && !st_defer) ? ch_sel : '0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (s.in_data[31:24] == SYNC) begin
              st_ch    <= s.in_data[CH_LSB +: CH_W];
              st_defer <= s.in_data[DEFER_BIT];
              to_cnt   <= '0;
              state    <= S_CAR;
            end else begin
              err_cnt <= sat_inc(err_cnt);
            end
          end
        end
        S_CAR, S_COD, S_PHA: begin
          if (accept) begin
            to_cnt <= '0;
            case (state)
              S_CAR:   begin st_car <= s.in_data[DW-1:0]; state <= S_COD; end
              S_COD:   begin st_cod <= s.in_data[DW-1:0]; state <= S_PHA; end
              default: begin
                st_pha     <= s.in_data[DW-1:0];
                state      <= S_COMMIT;
                in_ready_q <= 1'b0;
              end
            endcase
          end else if (to_cnt == TIMEOUT - 1'b1) begin
            to_cnt  <= '0;
            err_cnt <= sat_inc(err_cnt);
            state   <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    nco_cfg_chreg #(.DW(DW)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .wr_shadow (wr_shadow[k]),
      .defer     (st_defer),
      .wr_direct (direct_q[k]),
      .apply     (apply_strobe),
      .car_in    (st_car),
      .cod_in    (st_cod),
      .pha_in    (st_pha),
      .car       (fre_carrier[k*DW +: DW]),
      .cod       (fre_1023k[k*DW +: DW]),
      .pha       (pha_1023k[k*DW +: DW]),
      .pending   (pending[k]),
      .upd       (upd[k])
    );
  end

endmodule

// File: tb/tb_nco_cfg_loader.sv
module tb_nco_cfg_loader;
  localparam int NUM_CH = 8;
  localparam int DW     = 28;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic apply_strobe = 1'b0;
  logic [NUM_CH*DW-1:0] fre_carrier, fre_1023k, pha_1023k;
  logic [NUM_CH-1:0]    upd, pending;
  logic [7:0]           err_cnt;

  int nvec = 0;
  int nerr = 0;

  nco_cfg_loader_if bus();

  nco_cfg_loader #(.NUM_CH(NUM_CH), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .s            (bus),
    .apply_strobe (apply_strobe),
    .fre_carrier  (fre_carrier),
    .fre_1023k    (fre_1023k),
    .pha_1023k    (pha_1023k),
    .upd          (upd),
    .pending      (pending),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ch(input logic [NUM_CH*DW-1:0] v, input int k);
    return v[k*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word and hold it until accepted; bounded.
  task automatic send(input logic [31:0] w);
    bit done;
    done = 1'b0;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8 && !done; i++) begin
      done = bus.in_ready;
      tick();
    end
    if (!done) begin
      nvec++;
      nerr++;
      $display("FAIL send: word %h not accepted, observed in_ready=0 expected 1", w);
    end
  endtask

  task automatic packet(input logic [31:0] h, c, f, p);
    send(h); send(c); send(f); send(p);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    #12;
    chk("rst_in_ready", 256'(bus.in_ready), 256'(1));
    chk("rst_car",      256'(fre_carrier),  256'(0));
    chk("rst_err",      256'(err_cnt),      256'(0));
    rst = 1'b0;
    tick();

    // 1: immediate update of ch0, back-to-back words
    send(32'hA500_0000); send(32'h0123_4567); send(32'h0000_1000); send(32'h0000_0200);
    chk("t1_ready_commit", 256'(bus.in_ready), 256'(0));
    bus.in_valid = 1'b0;
    chk("t1_upd_n1", 256'(upd), 256'(0));
    tick();
    chk("t1_ready_after", 256'(bus.in_ready), 256'(1));
    chk("t1_car_n1", 256'(ch(fre_carrier, 0)), 256'(0));
    tick();
    chk("t1_car", 256'(ch(fre_carrier, 0)), 256'(28'h1234567));
    chk("t1_cod", 256'(ch(fre_1023k, 0)),   256'(28'h1000));
    chk("t1_pha", 256'(ch(pha_1023k, 0)),   256'(28'h200));
    chk("t1_upd", 256'(upd), 256'(8'h01));
    tick();
    chk("t1_upd_off", 256'(upd), 256'(8'h00));

    // 2: deferred ch3/ch5, then one strobe
    packet(32'hA503_8000, 32'h0333_3333, 32'h0000_0033, 32'h0000_0003);
    packet(32'hA505_8000, 32'h0555_5555, 32'h0000_0055, 32'h0000_0005);
    tick(); tick();
    chk("t2_pending", 256'(pending), 256'(8'h28));
    chk("t2_car3_old", 256'(ch(fre_carrier, 3)), 256'(0));
    chk("t2_upd_none", 256'(upd), 256'(0));
    apply_strobe = 1'b1;
    tick();
    apply_strobe = 1'b0;
    chk("t2_upd", 256'(upd), 256'(8'h28));
    chk("t2_car3", 256'(ch(fre_carrier, 3)), 256'(28'h3333333));
    chk("t2_cod5", 256'(ch(fre_1023k, 5)),   256'(28'h55));
    chk("t2_pending_clr", 256'(pending), 256'(0));
    chk("t2_car0_keep", 256'(ch(fre_carrier, 0)), 256'(28'h1234567));

    // 3: bad header dropped, then valid ch1 packet
    send(32'h5A00_0000);
    bus.in_valid = 1'b0;
    chk("t3_err", 256'(err_cnt), 256'(1));
    chk("t3_ready", 256'(bus.in_ready), 256'(1));
    packet(32'hA501_0000, 32'h00AB_CDEF, 32'h0000_0111, 32'h0000_0022);
    tick(); tick();
    chk("t3_car1", 256'(ch(fre_carrier, 1)), 256'(28'h0ABCDEF));
    chk("t3_upd",  256'(upd), 256'(8'h02));
    chk("t3_err_keep", 256'(err_cnt), 256'(1));

    // 4: truncated packet to ch4 times out
    send(32'hA504_0000); send(32'h0444_4444);
    bus.in_valid = 1'b0;
    repeat (1010) tick();
    chk("t4_err_before", 256'(err_cnt), 256'(1));
    repeat (20) tick();
    chk("t4_err_after", 256'(err_cnt), 256'(2));
    chk("t4_car4", 256'(ch(fre_carrier, 4)), 256'(0));
    chk("t4_pending", 256'(pending), 256'(0));
    packet(32'hA504_0000, 32'h00FE_DCBA, 32'h0000_0044, 32'h0000_0004);
    tick(); tick();
    chk("t4_car4_new", 256'(ch(fre_carrier, 4)), 256'(28'h0FEDCBA));
    chk("t4_cod4_new", 256'(ch(fre_1023k, 4)),   256'(28'h44));
    chk("t4_upd", 256'(upd), 256'(8'h10));

    // 5: deferred ch2 commit coincides with strobe
    packet(32'hA502_8000, 32'h0222_2222, 32'h0000_0022, 32'h0000_0002);
    tick();
    chk("t5_pending1", 256'(pending), 256'(8'h04));
    send(32'hA502_8000); send(32'h0BBB_BBBB); send(32'h0000_00BB); send(32'h0000_000B);
    bus.in_valid = 1'b0;
    apply_strobe = 1'b1;
    tick();
    apply_strobe = 1'b0;
    chk("t5_car2_old", 256'(ch(fre_carrier, 2)), 256'(28'h2222222));
    chk("t5_upd",      256'(upd), 256'(8'h04));
    chk("t5_pending2", 256'(pending), 256'(8'h04));
    tick();
    apply_strobe = 1'b1;
    tick();
    apply_strobe = 1'b0;
    chk("t5_car2_new", 256'(ch(fre_carrier, 2)), 256'(28'hBBBBBBB));
    chk("t5_pha2_new", 256'(ch(pha_1023k, 2)),   256'(28'hB));
    chk("t5_pending3", 256'(pending), 256'(0));

    // 6: async reset in W_COD
    send(32'hA506_0000); send(32'h0666_6666);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_car",     256'(fre_carrier), 256'(0));
    chk("t6_cod",     256'(fre_1023k),   256'(0));
    chk("t6_err",     256'(err_cnt),     256'(0));
    chk("t6_pending", 256'(pending),     256'(0));
    chk("t6_ready",   256'(bus.in_ready), 256'(1));
    tick();
    rst = 1'b0;
    tick();
    packet(32'hA506_0000, 32'h0777_7777, 32'h0000_0077, 32'h0000_0007);
    tick(); tick();
    chk("t6_car6", 256'(ch(fre_carrier, 6)), 256'(28'h7777777));
    chk("t6_upd",  256'(upd), 256'(8'h40));
    chk("t6_err_keep", 256'(err_cnt), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
